// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters, same-cycle lookup and EX resolve.
// Latency: lookup and resolve are combinational, training lands at the next clk_i edge; no backpressure.
module branch_predictor #(
  parameter int BTB_IDX_W = 6,
  parameter int TAG_W     = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] if_predict_pc_i,
  output logic        if_predict_taken_o,
  output logic [31:0] if_predict_targetPc_o,
  output logic        if_predict_failed_o,
  output logic [31:0] if_flush_pc_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_br_i,
  input  logic        ex_is_cond_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispredicts_o
);

  localparam int DEPTH = 1 << BTB_IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             uncond;
    logic [1:0]       ctr;
  } btb_entry_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  btb_entry_t       entry_q [DEPTH];
  logic [31:0]      branches_q, branches_d;
  logic [31:0]      mispredicts_q, mispredicts_d;

  // Fetch-side lookup
  logic [BTB_IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  btb_entry_t           lk_entry;
  logic                 lk_hit;

  assign lk_idx   = if_predict_pc_i[BTB_IDX_W+1:2];
  assign lk_tag   = if_predict_pc_i[31:BTB_IDX_W+2];
  assign lk_entry = entry_q[lk_idx];
  assign lk_hit   = valid_q[lk_idx] && (lk_entry.tag == lk_tag);

  assign if_predict_taken_o    = lk_hit && (lk_entry.uncond || lk_entry.ctr[1]);
  assign if_predict_targetPc_o = if_predict_taken_o ? lk_entry.target : if_predict_pc_i + 32'd4;

  // EX-side resolve
  logic fail_br, fail_nb, upd_en;

  assign fail_br = ex_is_br_i && ((ex_taken_i != ex_pred_taken_i) ||
                                  (ex_taken_i && (ex_target_i != ex_pred_target_i)));
  assign fail_nb = !ex_is_br_i && ex_pred_taken_i;
  assign upd_en  = ex_valid_i && !rst_i;

  assign if_predict_failed_o = upd_en && (fail_br || fail_nb);
  assign if_flush_pc_o       = (ex_is_br_i && ex_taken_i) ? ex_target_i : ex_pc_i + 32'd4;

  // Training
  logic [BTB_IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0]     ex_tag;
  btb_entry_t           ex_entry;
  btb_entry_t           upd_entry;
  logic                 ex_hit;
  logic                 upd_wr;

  assign ex_idx   = ex_pc_i[BTB_IDX_W+1:2];
  assign ex_tag   = ex_pc_i[31:BTB_IDX_W+2];
  assign ex_entry = entry_q[ex_idx];
  assign ex_hit   = valid_q[ex_idx] && (ex_entry.tag == ex_tag);

  always_comb begin
    valid_d   = valid_q;
    upd_wr    = 1'b0;
    upd_entry = ex_entry;
    if (upd_en) begin
      if (ex_is_br_i) begin
        if (ex_hit) begin
          upd_wr = 1'b1;
          if (ex_taken_i) begin
            upd_entry.ctr    = (ex_entry.ctr == 2'b11) ? 2'b11 : ex_entry.ctr + 2'd1;
            upd_entry.target = ex_target_i;
            upd_entry.uncond = !ex_is_cond_i;
          end else begin
            upd_entry.ctr    = (ex_entry.ctr == 2'b00) ? 2'b00 : ex_entry.ctr - 2'd1;
          end
        end else if (ex_taken_i) begin
          upd_wr          = 1'b1;
          valid_d[ex_idx] = 1'b1;
          upd_entry       = '{tag: ex_tag, target: ex_target_i, uncond: !ex_is_cond_i, ctr: 2'b10};
        end
      end else if (ex_hit) begin
        // A non-branch matched a BTB entry: the entry is stale, drop it.
        valid_d[ex_idx] = 1'b0;
      end
    end
  end

  always_comb begin
    branches_d    = branches_q;
    mispredicts_d = mispredicts_q;
    if (upd_en && ex_is_br_i) branches_d = branches_q + 32'd1;
    if (if_predict_failed_o)  mispredicts_d = mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q       <= '0;
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else begin
      valid_q       <= valid_d;
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  // Entry payload needs no reset; valid_q gates every use of it.
  always_ff @(posedge clk_i) begin
    if (upd_wr) entry_q[ex_idx] <= upd_entry;
  end

  assign stat_branches_o    = branches_q;
  assign stat_mispredicts_o = mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: reference BTB model checked every cycle plus directed literal checks.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        taken_o, failed_o;
  logic [31:0] target_o, flush_o, br_o, mp_o;
  logic        ex_valid, ex_is_br, ex_is_cond, ex_taken, ex_pt;
  logic [31:0] ex_pc, ex_tgt, ex_ptgt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk_i(clk), .rst_i(rst),
    .if_predict_pc_i(pc), .if_predict_taken_o(taken_o), .if_predict_targetPc_o(target_o),
    .if_predict_failed_o(failed_o), .if_flush_pc_o(flush_o),
    .ex_valid_i(ex_valid), .ex_is_br_i(ex_is_br), .ex_is_cond_i(ex_is_cond), .ex_pc_i(ex_pc),
    .ex_taken_i(ex_taken), .ex_target_i(ex_tgt), .ex_pred_taken_i(ex_pt),
    .ex_pred_target_i(ex_ptgt),
    .stat_branches_o(br_o), .stat_mispredicts_o(mp_o)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: one record per BTB slot, counter kept as a plain 0..3 integer.
  bit          m_valid [64];
  bit [23:0]   m_tag   [64];
  bit [31:0]   m_tgt   [64];
  bit          m_unc   [64];
  int          m_ctr   [64];
  bit [31:0]   m_br, m_mp;
  bit          started = 1'b0;

  function automatic int slot(input bit [31:0] a);
    return int'((a / 4) % 64);
  endfunction

  function automatic bit m_hit(input bit [31:0] a);
    return m_valid[slot(a)] && (m_tag[slot(a)] == a[31:8]);
  endfunction

  function automatic bit m_fail();
    bit wrong;
    if (rst || !ex_valid) return 1'b0;
    if (ex_is_br) wrong = (ex_taken != ex_pt) || (ex_taken && ex_tgt != ex_ptgt);
    else          wrong = ex_pt;
    return wrong;
  endfunction

  always @(posedge clk) begin
    int s;
    s = slot(ex_pc);
    if (rst) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      m_br = 0;
      m_mp = 0;
      started = 1'b1;
    end else if (ex_valid) begin
      if (ex_is_br) m_br = m_br + 1;
      if (m_fail()) m_mp = m_mp + 1;
      if (ex_is_br && m_hit(ex_pc)) begin
        if (ex_taken) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_tgt[s] = ex_tgt;
          m_unc[s] = !ex_is_cond;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (ex_is_br && ex_taken) begin
        m_valid[s] = 1'b1;
        m_tag[s]   = ex_pc[31:8];
        m_tgt[s]   = ex_tgt;
        m_unc[s]   = !ex_is_cond;
        m_ctr[s]   = 2;
      end else if (!ex_is_br && m_hit(ex_pc)) begin
        m_valid[s] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    bit          e_tk;
    bit [31:0]   e_tgt;
    if (started) begin
      e_tk  = m_hit(pc) && (m_unc[slot(pc)] || m_ctr[slot(pc)] >= 2);
      e_tgt = e_tk ? m_tgt[slot(pc)] : pc + 32'd4;
      chk("model taken", {31'd0, taken_o}, {31'd0, e_tk});
      chk("model target", target_o, e_tgt);
      chk("model failed", {31'd0, failed_o}, {31'd0, m_fail()});
      if (m_fail())
        chk("model flush", flush_o, (ex_is_br && ex_taken) ? ex_tgt : ex_pc + 32'd4);
      chk("model branches", br_o, m_br);
      chk("model mispredicts", mp_o, m_mp);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 0; ex_is_br = 0; ex_is_cond = 0; ex_taken = 0; ex_pt = 0;
    ex_pc = 0; ex_tgt = 0; ex_ptgt = 0;
  endtask

  task automatic resolve(input bit br, input bit cnd, input bit [31:0] a, input bit tk,
                         input bit [31:0] t, input bit ptk, input bit [31:0] pt);
    ex_valid = 1; ex_is_br = br; ex_is_cond = cnd; ex_pc = a;
    ex_taken = tk; ex_tgt = t; ex_pt = ptk; ex_ptgt = pt;
  endtask

  initial begin
    rst = 1;
    idle();
    pc = 32'h1c00_0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("reset taken", {31'd0, taken_o}, 32'd0);
    chk("reset target", target_o, 32'h1c00_0004);
    chk("reset branches", br_o, 32'd0);
    chk("reset mispredicts", mp_o, 32'd0);
    for (int k = 1; k <= 64; k++) begin
      pc = 32'h1c00_0000 + k * 4;
      cyc();
    end

    // Cold taken conditional branch: mispredict, allocate, visible one cycle later.
    pc = 32'h1c00_0010;
    resolve(1, 1, 32'h1c00_0010, 1, 32'h1c00_0080, 0, 32'h0);
    #1;
    chk("alloc failed", {31'd0, failed_o}, 32'd1);
    chk("alloc flush", flush_o, 32'h1c00_0080);
    chk("alloc no bypass", {31'd0, taken_o}, 32'd0);
    cyc();
    idle();
    #1;
    chk("alloc hit taken", {31'd0, taken_o}, 32'd1);
    chk("alloc hit target", target_o, 32'h1c00_0080);
    cyc();

    // Two not-taken resolutions walk the counter down to 00.
    for (int k = 0; k < 2; k++) begin
      resolve(1, 1, 32'h1c00_0010, 0, 32'h0, 1, 32'h1c00_0080);
      #1;
      chk("nt failed", {31'd0, failed_o}, 32'd1);
      chk("nt flush", flush_o, 32'h1c00_0014);
      cyc();
    end
    idle();
    #1;
    chk("nt lookup", {31'd0, taken_o}, 32'd0);
    cyc();

    // Saturate at 11; one not-taken still predicts taken.
    resolve(1, 1, 32'h1c00_0010, 1, 32'h1c00_0080, 0, 32'h0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      resolve(1, 1, 32'h1c00_0010, 1, 32'h1c00_0080, 1, 32'h1c00_0080);
      #1;
      chk("sat no fail", {31'd0, failed_o}, 32'd0);
      cyc();
    end
    resolve(1, 1, 32'h1c00_0010, 0, 32'h0, 1, 32'h1c00_0080);
    cyc();
    idle();
    #1;
    chk("sat lookup taken", {31'd0, taken_o}, 32'd1);
    chk("sat lookup target", target_o, 32'h1c00_0080);
    cyc();

    // Unconditional jump allocation.
    resolve(1, 0, 32'h1c00_0040, 1, 32'h1c00_0200, 0, 32'h0);
    pc = 32'h1c00_0040;
    cyc();
    idle();
    #1;
    chk("jump target", target_o, 32'h1c00_0200);
    cyc();

    // Non-branch in the same slot with a different tag leaves the entry alone.
    resolve(0, 0, 32'h1c00_0110, 0, 32'h0, 0, 32'h0);
    pc = 32'h1c00_0010;
    #1;
    chk("alias other tag failed", {31'd0, failed_o}, 32'd0);
    cyc();
    idle();
    #1;
    chk("alias other tag kept", {31'd0, taken_o}, 32'd1);
    cyc();

    // Non-branch hitting the entry with a taken prediction: flush to pc+4 and invalidate.
    resolve(0, 0, 32'h1c00_0010, 0, 32'h0, 1, 32'h1c00_0080);
    #1;
    chk("nb failed", {31'd0, failed_o}, 32'd1);
    chk("nb flush", flush_o, 32'h1c00_0014);
    cyc();
    idle();
    #1;
    chk("nb invalidated", {31'd0, taken_o}, 32'd0);
    chk("nb branches", br_o, 32'd9);
    chk("nb mispredicts", mp_o, 32'd7);
    cyc();

    // Reset wins over a same-cycle resolve.
    rst = 1;
    resolve(1, 1, 32'h1c00_0020, 1, 32'h1c00_0300, 0, 32'h0);
    #1;
    chk("rst failed", {31'd0, failed_o}, 32'd0);
    cyc();
    rst = 0;
    idle();
    pc = 32'h1c00_0020;
    #1;
    chk("rst branches", br_o, 32'd0);
    chk("rst mispredicts", mp_o, 32'd0);
    chk("rst no alloc", {31'd0, taken_o}, 32'd0);
    cyc();
    pc = 32'h1c00_0040;
    #1;
    chk("rst jump cleared", {31'd0, taken_o}, 32'd0);
    cyc();
    pc = 32'hffff_fffc;
    #1;
    chk("wrap target", target_o, 32'h0000_0000);
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
